// File: rtl/ecs_pulse_tx.sv
// Single-wire pulse-count transmitter: each SYM_W-bit symbol v is sent as v+1 one-cycle pulses.
// Latency: accept -> SETUP one cycle later -> first pulse one cycle after that; one-entry holding register.
// Backpressure: tx_ready low while the holding register is full; the engine drains it at frame start.
module ecs_pulse_tx #(
    parameter int DATA_W = 16,
    parameter int SYM_W  = 4,
    parameter int GAP    = 1,
    parameter int CHK_EN = 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic              tx_abort,
    output logic              TXSelect,
    output logic              RXSelect,
    output logic              TXBusy,
    output logic              frame_done,
    output logic              line_out
);

    localparam int NSYM = DATA_W / SYM_W;
    localparam int NTOT = NSYM + ((CHK_EN != 0) ? 1 : 0);
    localparam int IW   = $clog2(NTOT + 1);
    localparam int PW   = SYM_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PH, S_PL, S_GAP, S_END
    } state_t;

    state_t             state_q, state_d;
    logic               hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]  hold_dat_q, hold_dat_d;
    logic [DATA_W-1:0]  frame_q, frame_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic [SYM_W-1:0]   chk_q, chk_d;
    logic [3:0]         gcnt_q, gcnt_d;
    logic               line_q, line_d;
    logic               done_q, done_d;

    logic               accept, load, ld_sym, gap_last, abort_ok;
    logic [SYM_W-1:0]   sym_val;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            hold_valid_q <= 1'b0;
            hold_dat_q   <= '0;
            frame_q      <= '0;
            idx_q        <= '0;
            pcnt_q       <= '0;
            chk_q        <= '0;
            gcnt_q       <= '0;
            line_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_dat_q   <= hold_dat_d;
            frame_q      <= frame_d;
            idx_q        <= idx_d;
            pcnt_q       <= pcnt_d;
            chk_q        <= chk_d;
            gcnt_q       <= gcnt_d;
            line_q       <= line_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        pcnt_d   = pcnt_q;
        chk_d    = chk_q;
        gcnt_d   = gcnt_q;
        done_d   = 1'b0;
        load     = 1'b0;
        ld_sym   = 1'b0;
        accept   = tx_valid & ~hold_valid_q;
        gap_last = (gcnt_q == 4'(GAP - 1));
        abort_ok = tx_abort && (state_q inside {S_SETUP, S_PH, S_PL, S_GAP});
        // The checksum slot follows the last data symbol and reuses the normal pulse path.
        sym_val  = (idx_q == IW'(NSYM)) ? chk_q : frame_q[SYM_W-1:0];

        if (abort_ok) begin
            state_d = S_END;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hold_valid_q) begin
                        load    = 1'b1;
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: begin
                    ld_sym  = 1'b1;
                    state_d = S_PH;
                end
                S_PH: state_d = S_PL;
                S_PL: begin
                    gcnt_d = '0;
                    if (pcnt_q > PW'(1)) begin
                        pcnt_d  = pcnt_q - PW'(1);
                        state_d = S_PH;
                    end else if (idx_q == IW'(NTOT)) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        ld_sym  = 1'b1;
                        state_d = S_PH;
                    end else begin
                        gcnt_d = gcnt_q + 4'd1;
                    end
                end
                S_END: begin
                    if (gap_last) begin
                        done_d = 1'b1;
                        if (hold_valid_q) begin
                            load    = 1'b1;
                            state_d = S_SETUP;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        gcnt_d = gcnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (ld_sym) begin
            pcnt_d  = {1'b0, sym_val} + PW'(1);
            frame_d = frame_q >> SYM_W;
            chk_d   = chk_q + sym_val;
            idx_d   = idx_q + IW'(1);
        end
        if (load) begin
            frame_d = hold_dat_q;
            idx_d   = '0;
            pcnt_d  = '0;
            chk_d   = '0;
            gcnt_d  = '0;
        end

        hold_valid_d = accept | (hold_valid_q & ~load);
        hold_dat_d   = accept ? tx_data : hold_dat_q;
        line_d       = (state_d == S_PH);
    end

    always_comb begin
        tx_ready   = ~hold_valid_q;
        TXSelect   = (state_q != S_IDLE);
        RXSelect   = (state_q == S_IDLE);
        TXBusy     = hold_valid_q | (state_q != S_IDLE);
        frame_done = done_q;
        line_out   = line_q;
    end

endmodule

// File: tb/tb_ecs_pulse_tx.sv
// Bench for ecs_pulse_tx at default parameters: a line monitor extracts burst lengths and
// TXSelect run lengths, and each scenario compares them with burst lists computed from the word.
module tb_ecs_pulse_tx;

    logic        clk;
    logic        nRST;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        tx_abort;
    logic        TXSelect;
    logic        RXSelect;
    logic        TXBusy;
    logic        frame_done;
    logic        line_out;

    ecs_pulse_tx #(.DATA_W(16), .SYM_W(4), .GAP(1), .CHK_EN(1)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_abort   (tx_abort),
        .TXSelect   (TXSelect),
        .RXSelect   (RXSelect),
        .TXBusy     (TXBusy),
        .frame_done (frame_done),
        .line_out   (line_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Line monitor
    int bursts_q[$];
    int txsel_q[$];
    int cur_p = 0, low_run = 0, tx_run = 0, consec_err = 0, done_cnt = 0;
    bit prev_line = 1'b0;

    always @(negedge clk) begin
        if (!nRST) begin
            cur_p = 0; low_run = 0; tx_run = 0; prev_line = 1'b0;
        end else begin
            if (line_out) begin
                if (prev_line) consec_err++;
                cur_p++;
                low_run = 0;
            end else begin
                low_run++;
                if (low_run == 2 && cur_p > 0) begin
                    bursts_q.push_back(cur_p);
                    cur_p = 0;
                end
            end
            prev_line = line_out;
            if (TXSelect) tx_run++;
            else if (tx_run > 0) begin
                txsel_q.push_back(tx_run);
                tx_run = 0;
            end
            if (frame_done) done_cnt++;
        end
    end

    // Reference: pulses per burst and TXSelect length, straight from the word
    int exp_b[5];
    int exp_len;

    task automatic model(input logic [15:0] w);
        int s;
        int v;
        s = 0;
        exp_len = 1 + 5;
        for (int k = 0; k < 4; k++) begin
            v = (int'(w) >> (4 * k)) % 16;
            exp_b[k] = v + 1;
            s += v;
            exp_len += 2 * (v + 1);
        end
        exp_b[4] = (s % 16) + 1;
        exp_len += 2 * exp_b[4];
    endtask

    task automatic clear_mon();
        bursts_q.delete();
        txsel_q.delete();
        done_cnt   = 0;
        consec_err = 0;
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic send_word(input logic [15:0] d, input bit keep, output bit ok);
        ok = 1'b0;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int i = 0; i < 400; i++) begin
            if (tx_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!TXBusy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        nRST = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_abort = 1'b0;
        repeat (3) @(negedge clk);
        #2 nRST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({tx_ready, RXSelect, line_out, TXBusy, TXSelect, frame_done} !== 6'b110000) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: rdy/rx/line/busy/txs/done=%b required 110000", i,
                         {tx_ready, RXSelect, line_out, TXBusy, TXSelect, frame_done});
            end
        end
    endtask

    task automatic test_latency();
        tx_valid = 1'b1; tx_data = 16'h0005;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if ({TXBusy, tx_ready, TXSelect, line_out} !== 4'b1000) begin
            errors++;
            $display("FAIL lat_e0 busy/rdy/txs/line=%b required 1000", {TXBusy, tx_ready, TXSelect, line_out});
        end
        @(negedge clk);
        checks++;
        if ({TXSelect, RXSelect, line_out, tx_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL lat_e1 txs/rx/line/rdy=%b required 1001", {TXSelect, RXSelect, line_out, tx_ready});
        end
        @(negedge clk);
        checks++;
        if (line_out !== 1'b1) begin
            errors++;
            $display("FAIL lat_e2 line_out=%b required 1", line_out);
        end
        begin
            bit ok;
            wait_idle(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL lat_idle timeout got 0 required 1"); end
        end
    endtask

    // Sends one word alone and compares every burst, TXSelect length and frame_done count.
    task automatic test_frame(input logic [15:0] w, input string name);
        bit ok;
        clear_mon();
        model(w);
        send_word(w, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s accept timeout", name); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s idle timeout", name); end
        checks++;
        if (bursts_q.size() != 5) begin
            errors++;
            $display("FAIL %s bursts count=%0d required 5", name, bursts_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (bursts_q[k] != exp_b[k]) begin
                    errors++;
                    $display("FAIL %s burst%0d pulses=%0d required %0d", name, k, bursts_q[k], exp_b[k]);
                end
            end
        end
        checks++;
        if (txsel_q.size() != 1 || txsel_q[0] != exp_len) begin
            errors++;
            $display("FAIL %s txselect runs=%0d first=%0d required 1 run of %0d", name, txsel_q.size(),
                     (txsel_q.size() > 0) ? txsel_q[0] : -1, exp_len);
        end
        checks++;
        if (done_cnt != 1 || consec_err != 0) begin
            errors++;
            $display("FAIL %s frame_done=%0d double_high=%0d required 1 and 0", name, done_cnt, consec_err);
        end
    endtask

    task automatic test_known_words();
        test_frame(16'h0000, "zero_word");
        checks++;
        if (exp_len != 16 || txsel_q.size() != 1 || txsel_q[0] != 16) begin
            errors++;
            $display("FAIL zero_len txselect=%0d required 16", (txsel_q.size() > 0) ? txsel_q[0] : -1);
        end
        test_frame(16'h21F3, "word_21f3");
        checks++;
        if (bursts_q.size() != 5 || bursts_q[1] != 16 || bursts_q[4] != 6 ||
            txsel_q.size() != 1 || txsel_q[0] != 68) begin
            errors++;
            $display("FAIL word_21f3_fixed sym1=%0d chk=%0d len=%0d required 16 6 68",
                     (bursts_q.size() > 1) ? bursts_q[1] : -1, (bursts_q.size() > 4) ? bursts_q[4] : -1,
                     (txsel_q.size() > 0) ? txsel_q[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [15:0] w;
            w = 16'($urandom);
            test_frame(w, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        int b_all[$];
        int len_all;
        clear_mon();
        model(16'h0001);
        len_all = exp_len;
        for (int k = 0; k < 5; k++) b_all.push_back(exp_b[k]);
        model(16'h0002);
        len_all += exp_len;
        for (int k = 0; k < 5; k++) b_all.push_back(exp_b[k]);
        send_word(16'h0001, 1'b1, ok1);
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready tx_ready=%b required 0", tx_ready); end
        send_word(16'h0002, 1'b0, ok2);
        checks++;
        if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_accept ok=%b%b required 11", ok1, ok2); end
        checks++;
        if (TXSelect !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sending TXSelect=%b at second accept required 1", TXSelect);
        end
        wait_idle(ok3);
        checks++;
        if (!ok3) begin errors++; $display("FAIL b2b_idle timeout"); end
        checks++;
        if (txsel_q.size() != 1 || txsel_q[0] != len_all) begin
            errors++;
            $display("FAIL b2b_txselect runs=%0d first=%0d required 1 run of %0d", txsel_q.size(),
                     (txsel_q.size() > 0) ? txsel_q[0] : -1, len_all);
        end
        checks++;
        if (bursts_q != b_all) begin
            errors++;
            $display("FAIL b2b_bursts count=%0d required %0d matching bursts", bursts_q.size(), b_all.size());
        end
        checks++;
        if (done_cnt != 2 || consec_err != 0) begin
            errors++;
            $display("FAIL b2b_done frame_done=%0d double_high=%0d required 2 and 0", done_cnt, consec_err);
        end
    endtask

    task automatic test_abort();
        bit ok1, ok2, ok3, found;
        int highs;
        int b_all[$];
        clear_mon();
        model(16'h0123);
        b_all.push_back(3);
        for (int k = 0; k < 5; k++) b_all.push_back(exp_b[k]);
        send_word(16'h0F0F, 1'b0, ok1);
        send_word(16'h0123, 1'b0, ok2);
        highs = 0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (line_out) highs++;
            if (highs == 3) begin
                found = 1'b1;
                tx_abort = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!(ok1 && ok2 && found)) begin
            errors++;
            $display("FAIL abort_setup accept=%b%b third_pulse=%b required 111", ok1, ok2, found);
        end
        @(negedge clk);
        tx_abort = 1'b0;
        checks++;
        if ({line_out, TXSelect, tx_ready} !== 3'b010) begin
            errors++;
            $display("FAIL abort_edge line/txs/rdy=%b required 010", {line_out, TXSelect, tx_ready});
        end
        wait_idle(ok3);
        checks++;
        if (!ok3) begin errors++; $display("FAIL abort_idle timeout"); end
        checks++;
        if (bursts_q != b_all) begin
            errors++;
            $display("FAIL abort_bursts count=%0d first=%0d required %0d bursts starting 3", bursts_q.size(),
                     (bursts_q.size() > 0) ? bursts_q[0] : -1, b_all.size());
        end
        checks++;
        if (txsel_q.size() != 1 || txsel_q[0] != 7 + exp_len) begin
            errors++;
            $display("FAIL abort_txselect first=%0d required %0d", (txsel_q.size() > 0) ? txsel_q[0] : -1,
                     7 + exp_len);
        end
        checks++;
        if (done_cnt != 2 || consec_err != 0) begin
            errors++;
            $display("FAIL abort_done frame_done=%0d double_high=%0d required 2 and 0", done_cnt, consec_err);
        end
    endtask

    task automatic test_async_reset();
        bit ok1, ok2, found;
        clear_mon();
        send_word(16'h00FF, 1'b0, ok1);
        send_word(16'h1111, 1'b0, ok2);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (line_out) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!(ok1 && ok2 && found && !tx_ready)) begin
            errors++;
            $display("FAIL arst_setup accept=%b%b high=%b ready=%b required 1110", ok1, ok2, found, tx_ready);
        end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({line_out, RXSelect, TXSelect, tx_ready, TXBusy, frame_done} !== 6'b010100) begin
            errors++;
            $display("FAIL arst_immediate line/rx/txs/rdy/busy/done=%b required 010100",
                     {line_out, RXSelect, TXSelect, tx_ready, TXBusy, frame_done});
        end
        @(negedge clk);
        #2 nRST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({line_out, TXBusy, TXSelect, tx_ready} !== 4'b0001) begin
                errors++;
                $display("FAIL arst_after cycle %0d line/busy/txs/rdy=%b required 0001", i,
                         {line_out, TXBusy, TXSelect, tx_ready});
            end
        end
        checks++;
        if (bursts_q.size() != 0 || txsel_q.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL arst_discard bursts=%0d runs=%0d done=%0d required 0 0 0", bursts_q.size(),
                     txsel_q.size(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_known_words();
        test_random();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
